// File: rtl/ram_loader_if.sv
// Bus bundle between ram_loader and its surroundings: command port, host byte links, RAM port.
// The master modport is the loader's view, and the slave modport is the environment's view.
interface ram_loader_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
);
  logic              cmd_start;
  logic              cmd_mode;
  logic [AWIDTH-1:0] cmd_base;
  logic [AWIDTH-1:0] cmd_len;
  logic              busy;
  logic              done;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  logic              ram_load;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_d;
  logic [DWIDTH-1:0] ram_q;

  modport master (
    input  cmd_start, cmd_mode, cmd_base, cmd_len,
    input  rx_data, rx_valid, tx_ready, ram_q,
    output busy, done, rx_ready, tx_data, tx_valid,
    output ram_load, ram_addr, ram_d
  );

  modport slave (
    output cmd_start, cmd_mode, cmd_base, cmd_len,
    output rx_data, rx_valid, tx_ready, ram_q,
    input  busy, done, rx_ready, tx_data, tx_valid,
    input  ram_load, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_loader.sv
// Program-RAM loader/dumper: packs host bytes big-endian into words and writes them to RAM,
// or reads a RAM range back through the registered q port and streams it out as bytes.
module ram_loader #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_loader_if.master bus
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LD_HI   = 4'd1;
  localparam logic [3:0] LD_LO   = 4'd2;
  localparam logic [3:0] LD_WR   = 4'd3;
  localparam logic [3:0] RD_ADDR = 4'd4;
  localparam logic [3:0] RD_CAP  = 4'd5;
  localparam logic [3:0] TX_HI   = 4'd6;
  localparam logic [3:0] TX_LO   = 4'd7;
  localparam logic [3:0] DONE    = 4'd8;

  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
  localparam logic [AWIDTH:0]   REM_ONE  = (AWIDTH + 1)'(1);

  logic [3:0]        state;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH:0]   remaining;   // one bit wider so a count of 4096 words fits
  logic [7:0]        hi_byte;
  logic [DWIDTH-1:0] word_buf;

  logic rx_fire;
  logic tx_fire;
  logic last_word;

  assign rx_fire   = bus.rx_valid & bus.rx_ready;
  assign tx_fire   = bus.tx_valid & bus.tx_ready;
  assign last_word = (remaining == REM_ONE);

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the byte/word buffers are plain registers, not a memory, so they reset with the rest.
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      hi_byte      <= '0;
      word_buf     <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rx_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.ram_load <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_d    <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.ram_load <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            addr      <= bus.cmd_base;
            remaining <= {1'b0, bus.cmd_len} + REM_ONE;
            bus.busy  <= 1'b1;
            if (bus.cmd_mode) begin
              state        <= RD_ADDR;
              bus.ram_addr <= bus.cmd_base;
            end else begin
              state        <= LD_HI;
              bus.rx_ready <= 1'b1;
            end
          end
        end

        LD_HI: begin
          if (rx_fire) begin
            hi_byte <= bus.rx_data;
            state   <= LD_LO;
          end
        end

        LD_LO: begin
          if (rx_fire) begin
            bus.ram_d    <= {hi_byte, bus.rx_data};
            bus.ram_addr <= addr;
            bus.ram_load <= 1'b1;
            bus.rx_ready <= 1'b0;
            state        <= LD_WR;
          end
        end

        // ram_load is high for exactly this cycle; the next word starts right after.
        LD_WR: begin
          addr      <= addr + ADDR_ONE;
          remaining <= remaining - REM_ONE;
          if (last_word) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state        <= LD_HI;
            bus.rx_ready <= 1'b1;
          end
        end

        // ram_addr is already presented; the RAM registers q at the end of this cycle.
        RD_ADDR: state <= RD_CAP;

        RD_CAP: begin
          word_buf     <= bus.ram_q;
          bus.tx_data  <= bus.ram_q[DWIDTH-1 -: 8];
          bus.tx_valid <= 1'b1;
          state        <= TX_HI;
        end

        TX_HI: begin
          if (tx_fire) begin
            bus.tx_data <= word_buf[7:0];
            state       <= TX_LO;
          end
        end

        TX_LO: begin
          if (tx_fire) begin
            bus.tx_valid <= 1'b0;
            addr         <= addr + ADDR_ONE;
            remaining    <= remaining - REM_ONE;
            if (last_word) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= RD_ADDR;
              bus.ram_addr <= addr + ADDR_ONE;
            end
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.rx_ready <= 1'b0;
          bus.tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a registered-read RAM model plus a word-level reference
// memory; directed and randomized load/dump operations are compared against it.
module tb_ram_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;

  ram_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  ram_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model with a one-cycle registered read.
  logic [DW-1:0] ram [4096];
  always @(posedge clk) begin
    if (bus.ram_load) ram[bus.ram_addr] <= bus.ram_d;
    bus.ram_q <= ram[bus.ram_addr];
  end

  // Monitor, sampling on the falling edge where everything is stable.
  logic [AW+DW-1:0] wr_q[$];
  logic [7:0]       tx_q[$];
  int load_cnt  = 0;
  int done_cnt  = 0;
  int busy_cyc  = 0;
  int stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (bus.ram_load) begin
      wr_q.push_back({bus.ram_addr, bus.ram_d});
      load_cnt <= load_cnt + 1;
    end
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.busy) busy_cyc <= busy_cyc + 1;
    if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_data)) stall_err <= stall_err + 1;
    prev_stall <= bus.tx_valid && !bus.tx_ready && rst_n;
    prev_data  <= bus.tx_data;
  end

  // Reference model: word-addressed memory image and the expected transaction lists.
  logic [DW-1:0]    ref_mem [4096];
  logic [7:0]       byte_q[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [7:0]       exp_tx[$];
  logic [7:0]       saved_tx[$];
  bit               seen [4096];

  int vectors     = 0;
  int miscompares = 0;
  int busy_base, done_base, load_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic mode, input logic [AW-1:0] base, input logic [AW-1:0] len);
    bus.cmd_start = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    busy_base = busy_cyc;
    done_base = done_cnt;
    load_base = load_cnt;
    step();
    bus.cmd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rx_ready) break;
    end
    check("rx_handshake_timeout", 32'(n < 20), 32'd1);
    step();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    step();
  endtask

  task automatic finish_op(input string tag, input int exp_busy, input int exp_loads);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check({tag, "_busy_after"}, bus.busy, 1'b0);
    check({tag, "_load_pulses"}, load_cnt - load_base, exp_loads);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cyc - busy_base, exp_busy);
  endtask

  // Load len+1 words from byte_q; the reference image is updated from the byte-pair rule.
  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len,
                         input bit thr, input int poke);
    exp_wr.delete();
    wr_q.delete();
    for (int w = 0; w <= int'(len); w++) begin
      int a;
      logic [DW-1:0] d;
      a = (int'(base) + w) % 4096;
      d = {byte_q[2*w], byte_q[2*w+1]};
      ref_mem[a] = d;
      exp_wr.push_back({AW'(a), d});
    end
    start_cmd(1'b0, base, len);
    for (int i = 0; i < 2 * (int'(len) + 1); i++) begin
      if (thr) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rx_valid = 1'b0;
          step();
        end
      end
      bus.cmd_start = (i == poke);
      if (i == poke) begin
        bus.cmd_mode = 1'b1;
        bus.cmd_base = 12'h555;
      end
      send_byte(byte_q[i]);
    end
    bus.cmd_start = 1'b0;
    bus.cmd_mode  = 1'b0;
    bus.rx_valid  = 1'b0;
    wait_idle("load", 20000);
  endtask

  task automatic do_dump(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit thr);
    int n;
    exp_tx.delete();
    tx_q.delete();
    for (int w = 0; w <= int'(len); w++) begin
      exp_tx.push_back(ref_mem[(int'(base) + w) % 4096][15:8]);
      exp_tx.push_back(ref_mem[(int'(base) + w) % 4096][7:0]);
    end
    start_cmd(1'b1, base, len);
    for (n = 0; n < 40000; n++) begin
      bus.tx_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!bus.busy) break;
      step();
    end
    check("dump_timeout", 32'(n < 40000), 32'd1);
    bus.tx_ready = 1'b0;
    step();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr[%0d]", tag, i), wr_q[i], exp_wr[i]);
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_tx_count"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx[%0d]", tag, i), tx_q[i], exp_tx[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     bus.busy,     1'b0);
    check({tag, "_done"},     bus.done,     1'b0);
    check({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    check({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
    check({tag, "_ram_load"}, bus.ram_load, 1'b0);
    check({tag, "_tx_data"},  bus.tx_data,  8'h00);
    check({tag, "_ram_addr"}, bus.ram_addr, 12'h000);
    check({tag, "_ram_d"},    bus.ram_d,    16'h0000);
  endtask

  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_mode  = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.tx_ready  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Basic load: two words at 0x010 with rx_valid held high (3 cycles per word + DONE).
    byte_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    do_load(12'h010, 12'd1, 1'b0, -1);
    compare_writes("load1");
    finish_op("load1", 7, 2);

    // Dump the same range unthrottled (4 cycles per word + DONE).
    do_dump(12'h010, 12'd1, 1'b0);
    compare_tx("dump1");
    check("dump1_first_byte", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h12);
    finish_op("dump1", 9, 0);
    saved_tx = tx_q;

    // Address wrap.
    byte_q = '{8'h00, 8'h01, 8'h00, 8'h02};
    do_load(12'hFFF, 12'd1, 1'b0, -1);
    compare_writes("wrap");
    finish_op("wrap", 7, 2);

    // Backpressured dump must reproduce the unthrottled byte stream.
    do_dump(12'h010, 12'd1, 1'b1);
    compare_tx("bp");
    check("bp_vs_free_count", tx_q.size(), saved_tx.size());
    for (int i = 0; i < saved_tx.size() && i < tx_q.size(); i++)
      check($sformatf("bp_vs_free[%0d]", i), tx_q[i], saved_tx[i]);
    finish_op("bp", -1, 0);

    // Reset after the first load byte: nothing is written, outputs clear at once.
    wr_q.delete();
    load_base = load_cnt;
    start_cmd(1'b0, 12'h200, 12'd0);
    send_byte(8'h55);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    check("midrst_no_write", wr_q.size(), 0);
    check("midrst_no_load", load_cnt - load_base, 0);
    byte_q = '{8'h9A, 8'hBC};
    do_load(12'h020, 12'd0, 1'b0, -1);
    compare_writes("postrst");
    finish_op("postrst", 4, 1);

    // Full memory with a counting pattern and a stray cmd_start mid-operation.
    byte_q.delete();
    for (int i = 0; i < 8192; i++) byte_q.push_back(8'(i));
    do_load(12'h000, 12'd4095, 1'b0, 1001);
    compare_writes("full");
    finish_op("full", 3 * 4096 + 1, 4096);
    begin
      int uniq;
      uniq = 0;
      foreach (wr_q[i]) begin
        if (!seen[wr_q[i][AW+DW-1:DW]]) begin
          seen[wr_q[i][AW+DW-1:DW]] = 1'b1;
          uniq++;
        end
      end
      check("full_coverage", uniq, 4096);
    end
    do_dump(12'h000, 12'd4095, 1'b0);
    compare_tx("full_dump");
    finish_op("full_dump", 4 * 4096 + 1, 0);

    // Randomized rounds: throttled loads and dumps, the first one straddling the wrap.
    for (int r = 0; r < 4; r++) begin
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      base = (r == 0) ? 12'hFFC : AW'($urandom_range(0, 4095));
      len  = AW'($urandom_range(0, 7));
      byte_q.delete();
      for (int i = 0; i < 2 * (int'(len) + 1); i++) byte_q.push_back(8'($urandom));
      do_load(base, len, 1'b1, -1);
      compare_writes($sformatf("rnd%0d_load", r));
      finish_op($sformatf("rnd%0d_load", r), -1, int'(len) + 1);
      do_dump(base, len, 1'b1);
      compare_tx($sformatf("rnd%0d_dump", r));
      finish_op($sformatf("rnd%0d_dump", r), -1, 0);
    end

    check("tx_stable_while_stalled", stall_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
